// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the burst memory slice.
// Holds the default parameter constants and the controller state encoding.
package mem_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_RD_LAT = 2;
    localparam int unsigned DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/burst_memory_if.sv
// burst_memory_if: request / write-beat / read-beat bundle of the burst memory.
//   req_valid/req_ready/req_we/req_addr/req_len : burst request handshake
//   wr_valid/wr_ready/wr_data                   : write beat handshake
//   rd_valid/rd_data                            : read beats (no backpressure)
//   busy                                        : controller not idle
// master = requester side, slave = memory side.
interface burst_memory_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, busy
    );

endinterface

// File: rtl/rd_pipe.sv
// rd_pipe: read-latency shift register (valid + data, RD_LAT stages).
//   clk, rst_n          : clock, synchronous active-low reset (clears all stages)
//   in_valid, in_data   : read issued this cycle and its array data
//   out_valid, out_data : beat RD_LAT cycles later; data is zero when not valid
//   pending             : a read is still travelling behind the output stage
module rd_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              pending
);

    // Every stage except the output one.
    localparam logic [RD_LAT-1:0] INNER_MASK = {RD_LAT{1'b1}} >> 1;

    logic [RD_LAT-1:0] v;
    logic [DATA_W-1:0] d [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                d[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            // Zero data on idle slots so rd_data reads 0 whenever rd_valid is low.
            d[0] <= in_valid ? in_data : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[RD_LAT-1];
    assign out_data  = d[RD_LAT-1];
    assign pending   = |(v & INNER_MASK);

endmodule

// File: rtl/burst_memory.sv
// burst_memory: single-port word memory with burst read/write controller.
//   clk   : clock, all logic on rising edge
//   rst_n : synchronous active-low reset (controller and read pipe only;
//           memory contents survive)
//   bus   : burst_memory_if slave (request, write beats, read beats, busy)
// Reads issue one per cycle and return RD_LAT cycles later in address order.
module burst_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input logic           clk,
    input logic           rst_n,
    burst_memory_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx, ptr_inc, start_idx;
    logic [LEN_W-1:0]  cnt, cnt_nx;
    logic              issue, wr_en, pending, rd_v;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] mem [DEPTH];

    // One extra bit keeps the divisor nonzero when DEPTH == 2**ADDR_W.
    assign start_idx = IDX_W'({1'b0, bus.req_addr} % (ADDR_W + 1)'(DEPTH));
    assign ptr_inc   = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        issue    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ptr_nx   = start_idx;
                    cnt_nx   = bus.req_len;
                    state_nx = bus.req_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus.wr_valid) begin
                    wr_en  = 1'b1;
                    ptr_nx = ptr_inc;
                    if (cnt == '0) state_nx = ST_IDLE;
                    else           cnt_nx   = cnt - 1'b1;
                end
            end
            ST_READ: begin
                issue  = 1'b1;
                ptr_nx = ptr_inc;
                if (cnt == '0) state_nx = ST_DRAIN;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_DRAIN: begin
                // Leave once only the output stage can still hold a beat, so
                // the last rd_valid cycle is the final DRAIN cycle.
                if (!pending) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    rd_pipe #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (issue),
        .in_data  (mem[ptr]),
        .out_valid(rd_v),
        .out_data (rd_d),
        .pending  (pending)
    );

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.wr_ready  = (state == ST_WRITE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rd_valid  = rd_v;
    assign bus.rd_data   = rd_d;

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: self-checking bench for burst_memory.
// Table-driven directed bursts, hand-written corner sequences (stall, held
// request, reset mid-read, reset mid-write) and randomized bursts checked
// against an array model of memory contents.
module tb_burst_memory;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned LEN_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    burst_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    burst_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT),
        .LEN_W (LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [3:0]  len;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mdl [DEPTH];
    bit          mw  [DEPTH];
    logic [7:0]  wq [$];
    int          sq [$];
    logic [7:0]  cap [$];
    vec_t        tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got %b expected 1", bus.req_ready);
        end
    endtask

    // Caller fills wq (data) and sq (idle cycles before each beat).
    task automatic do_write(input logic [15:0] addr, input logic [3:0] len);
        int unsigned a;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        chk("wr_ready_in_burst", 32'(bus.wr_ready), 32'd1);
        chk("req_ready_in_burst", 32'(bus.req_ready), 32'd0);
        a = 32'(addr) % DEPTH;
        for (int i = 0; i <= int'(len); i++) begin
            for (int s = 0; s < sq[i]; s++) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'($urandom);
                @(negedge clk);
                chk("busy_stall", 32'(bus.busy), 32'd1);
                chk("wr_ready_stall", 32'(bus.wr_ready), 32'd1);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wq[i];
            @(negedge clk);
            mdl[a] = wq[i];
            mw[a]  = 1'b1;
            a = (a + 1) % DEPTH;
        end
        bus.wr_valid = 1'b0;
        chk("wr_done_req_ready", 32'(bus.req_ready), 32'd1);
        chk("wr_done_busy", 32'(bus.busy), 32'd0);
        chk("wr_done_wr_ready", 32'(bus.wr_ready), 32'd0);
    endtask

    // Checks beat timing cycle by cycle and collects beats into cap.
    // hold keeps req_valid high with (a2,l2) for the whole burst.
    task automatic do_read(input logic [15:0] addr, input logic [3:0] len,
                           input bit hold, input logic [15:0] a2, input logic [3:0] l2);
        int  last;
        bit  exp_v;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        bus.req_len   = len;
        cap.delete();
        last = 1 + int'(RD_LAT) + int'(len);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            exp_v = (c >= 1 + int'(RD_LAT)) && (c <= last);
            chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
            if (bus.rd_valid === 1'b1) cap.push_back(bus.rd_data);
            else chk("rd_data_idle", 32'(bus.rd_data), 32'd0);
            chk("rd_req_ready", 32'(bus.req_ready), 32'(c == last + 1));
            chk("rd_busy", 32'(bus.busy), 32'(c <= last));
            if (c == 1) begin
                if (hold) begin
                    bus.req_addr = a2;
                    bus.req_len  = l2;
                    bus.req_we   = 1'b0;
                end else begin
                    bus.req_valid = 1'b0;
                    bus.req_we    = 1'b1;
                end
            end
        end
    endtask

    task automatic set_beats(input logic [7:0] d0, input logic [7:0] d1);
        wq.delete();
        sq.delete();
        wq.push_back(d0);
        wq.push_back(d1);
        sq.push_back(0);
        sq.push_back(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        logic [15:0] ra;
        logic [3:0]  rl;

        tbl[0]  = '{1'b1, 16'h0000, 4'd1, 8'hAA, 8'hBB};
        tbl[1]  = '{1'b0, 16'h0000, 4'd1, 8'hAA, 8'hBB};
        tbl[2]  = '{1'b1, 16'h0001, 4'd0, 8'hBB, 8'h00};
        tbl[3]  = '{1'b0, 16'h0000, 4'd0, 8'hAA, 8'h00};
        tbl[4]  = '{1'b0, 16'h0001, 4'd0, 8'hBB, 8'h00};
        tbl[5]  = '{1'b1, 16'h00FF, 4'd1, 8'h11, 8'h22};
        tbl[6]  = '{1'b0, 16'h0000, 4'd0, 8'h22, 8'h00};
        tbl[7]  = '{1'b0, 16'h00FF, 4'd0, 8'h11, 8'h00};
        tbl[8]  = '{1'b0, 16'h00FF, 4'd1, 8'h11, 8'h22};
        tbl[9]  = '{1'b0, 16'h01FF, 4'd0, 8'h11, 8'h00};
        tbl[10] = '{1'b1, 16'h1234, 4'd0, 8'hC3, 8'h00};
        tbl[11] = '{1'b0, 16'h0034, 4'd0, 8'hC3, 8'h00};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < int'(DEPTH); i++) mw[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd0);

        // Directed table
        for (int t = 0; t < 12; t++) begin
            if (tbl[t].we) begin
                set_beats(tbl[t].d0, tbl[t].d1);
                do_write(tbl[t].addr, tbl[t].len);
            end else begin
                do_read(tbl[t].addr, tbl[t].len, 1'b0, '0, '0);
                chk("tbl_beats", 32'(cap.size()), 32'(tbl[t].len) + 32'd1);
                if (cap.size() > 0) chk("tbl_d0", 32'(cap[0]), 32'(tbl[t].d0));
                if (cap.size() > 1) chk("tbl_d1", 32'(cap[1]), 32'(tbl[t].d1));
            end
        end

        // Write stall: 3 idle cycles between beats, neighbour must stay intact
        set_beats(8'h77, 8'h00);
        do_write(16'h0012, 4'd0);
        set_beats(8'h5A, 8'hA5);
        sq[1] = 3;
        do_write(16'h0010, 4'd1);
        do_read(16'h0010, 4'd2, 1'b0, '0, '0);
        chk("stall_beats", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            chk("stall_d0", 32'(cap[0]), 32'h5A);
            chk("stall_d1", 32'(cap[1]), 32'hA5);
            chk("stall_d2", 32'(cap[2]), 32'h77);
        end

        // Held request during a read burst: accepted only after last beat
        do_read(16'h0010, 4'd2, 1'b1, 16'h00FF, 4'd0);
        chk("hold_beats", 32'(cap.size()), 32'd3);
        do_read(16'h00FF, 4'd0, 1'b0, '0, '0);
        chk("hold_second_beats", 32'(cap.size()), 32'd1);
        if (cap.size() == 1) chk("hold_second_d0", 32'(cap[0]), 32'h11);

        // Reset mid-read
        wq.delete();
        sq.delete();
        for (int i = 0; i < 8; i++) begin
            wq.push_back(8'(i * 17 + 3));
            sq.push_back(0);
        end
        do_write(16'h0040, 4'd7);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0040;
        bus.req_len   = 4'd7;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("rstrd_valid", 32'(bus.rd_valid), 32'(c == 3));
        end
        chk("rstrd_first", 32'(bus.rd_data), 32'h03);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstrd_valid_after", 32'(bus.rd_valid), 32'd0);
        chk("rstrd_data_after", 32'(bus.rd_data), 32'd0);
        chk("rstrd_busy_after", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrd_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstrd_wr_ready", 32'(bus.wr_ready), 32'd0);
        do_read(16'h0040, 4'd7, 1'b0, '0, '0);
        chk("rstrd_reread_beats", 32'(cap.size()), 32'd8);
        for (int i = 0; i < cap.size(); i++) chk("rstrd_reread", 32'(cap[i]), 32'(i * 17 + 3));

        // Reset mid-write: accepted beats survive
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0080;
        bus.req_len   = 4'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 8'hE1;
        @(negedge clk);
        bus.wr_data   = 8'hE2;
        @(negedge clk);
        bus.wr_valid  = 1'b0;
        mdl[8'h80] = 8'hE1; mw[8'h80] = 1'b1;
        mdl[8'h81] = 8'hE2; mw[8'h81] = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwr_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(16'h0080, 4'd1, 1'b0, '0, '0);
        chk("rstwr_beats", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("rstwr_d0", 32'(cap[0]), 32'hE1);
            chk("rstwr_d1", 32'(cap[1]), 32'hE2);
        end

        // Randomized bursts against the array model (window wraps past 0xFF)
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom_range(200, 247)) + (16'($urandom_range(0, 255)) << 8);
            rl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                sq.delete();
                for (int i = 0; i <= int'(rl); i++) begin
                    wq.push_back(8'($urandom));
                    sq.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
                end
                do_write(ra, rl);
            end else begin
                do_read(ra, rl, 1'b0, '0, '0);
                chk("rand_beats", 32'(cap.size()), 32'(rl) + 32'd1);
                a = 32'(ra) % DEPTH;
                for (int i = 0; i < cap.size(); i++) begin
                    if (mw[a]) chk("rand_data", 32'(cap[i]), 32'(mdl[a]));
                    a = (a + 1) % DEPTH;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of words stored (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter RD_LAT, default 2, meaning read latency in cycles (legal range 1..4).
REQ-005 SHALL have parameter LEN_W, default 4, meaning burst length field width (max burst 2**LEN_W beats).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning the reset: synchronous and active-low.
REQ-008 SHALL have port req_valid, input, 1, meaning a burst request is offered.
REQ-009 SHALL have port req_ready, output, 1, meaning a burst request is accepted this cycle.
REQ-010 SHALL have port req_we, input, 1, meaning 1 = write burst, 0 = read burst.
REQ-011 SHALL have port req_addr, input, ADDR_W, meaning the start address.
REQ-012 SHALL have port req_len, input, LEN_W, meaning beats minus one.
REQ-013 SHALL have port wr_valid, input, 1, meaning the write beat is valid.
REQ-014 SHALL have port wr_ready, output, 1, meaning the write beat is accepted.
REQ-015 SHALL have port wr_data, input, DATA_W, meaning the write beat data.
REQ-016 SHALL have port rd_valid, output, 1, meaning the read beat is valid (no backpressure).
REQ-017 SHALL have port rd_data, output, DATA_W, meaning the read beat data.
REQ-018 SHALL have port busy, output, 1, meaning the block is not in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, DRAIN; req_ready = (state==IDLE), wr_ready = (state==WRITE), busy = (state!=IDLE).
REQ-020 In IDLE, when req_valid is high, SHALL latch the address as req_addr mod DEPTH, the remaining count as req_len, and enter WRITE if req_we else READ; otherwise SHALL stay in IDLE.
REQ-021 While req_ready is low, SHALL ignore all req_* inputs.
REQ-022 In WRITE, on each cycle with wr_valid high, SHALL store wr_data at the current address, then advance the address modulo DEPTH; cycles with wr_valid low SHALL stall with no state change.
REQ-023 SHALL make written data readable by any request accepted on or after the cycle following the write.
REQ-024 After accepting req_len+1 write beats, SHALL return to IDLE on the next edge, so req_ready is high on the following cycle.
REQ-025 In READ, SHALL issue one read per cycle at the current address, advancing modulo DEPTH; after req_len+1 issues it SHALL enter DRAIN.
REQ-026 For each read issue at cycle N, SHALL assert rd_valid with the corresponding rd_data exactly in cycle N+RD_LAT.
REQ-027 Read beats SHALL appear in consecutive cycles, in address order.
REQ-028 In DRAIN, SHALL return to IDLE once no read remains in flight, so the last rd_valid and the return to IDLE coincide.
REQ-029 An address increment from DEPTH-1 SHALL wrap to 0.
REQ-030 When rd_valid is low, rd_data SHALL hold 0.
REQ-031 Memory contents SHALL be undefined until written.

Reset
REQ-032 SHALL, on any clock edge with rst_n low, force state IDLE, clear the read pipeline, and set rd_valid=0, rd_data=0, busy=0.
REQ-033 SHALL have req_ready=1 and wr_ready=0 on the first cycle after reset release.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 A reset received mid-burst SHALL abort the burst: write beats already accepted remain stored, and reads in flight are discarded.

Structure
REQ-036 Shared package mem_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-037 The read-latency shift register (valid plus data, RD_LAT stages) SHALL be sub-module rd_pipe; the storage array and FSM SHALL reside in burst_memory.

Verification
REQ-038 Bench SHALL cover: write burst at 0x0000, len=1, data AA,BB; then read 0x0000, len=1 -> rd_data AA then BB on consecutive cycles, first beat 2 cycles after the first issue.
REQ-039 Bench SHALL cover: write 0xBB at 0x0001, then read 0x0000, len=0 -> AA; then read 0x0001, len=0 -> BB.
REQ-040 Bench SHALL cover wrap: DEPTH=256, write at 0x00FF, len=1, data 11,22 -> a read at 0x0000 returns 22 and a read at 0x00FF returns 11.
REQ-041 Bench SHALL cover write stall: wr_valid low for 3 cycles between beats -> busy stays high, no extra write occurs, and the burst completes after the final beat.
REQ-042 Bench SHALL cover overlapped request: req_valid held high during a read burst -> not accepted until req_ready returns high after the final rd_valid.
REQ-043 Bench SHALL cover reset mid-read (len=7, rst_n low after 3 issues) -> rd_valid=0 the next cycle, busy=0, and earlier-written data is intact on re-read.
